// File: rtl/aim65_kbd_matrix.sv
// PS/2 key events from hps_io mapped onto the AIM-65 8x8 active-low keyboard matrix.
// Releases that come too soon after a press are held back, so slow firmware scans still see short taps.
module aim65_kbd_matrix #(
   parameter int unsigned MIN_HOLD = 50000,
   parameter int unsigned RQ_DEPTH = 4
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic        kbd_en,
   input  logic [7:0]  col_sel,
   output logic [7:0]  row_out,
   output logic        key_event,
   output logic        rq_overflow
);

   localparam int unsigned HW = $clog2(MIN_HOLD + 1);
   localparam int unsigned AW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StLookup, StApply} state_e;

   // Returns {valid, row[2:0], col[2:0]}
   function automatic logic [6:0] kbd_map(input logic ext, input logic [7:0] code);
      logic [6:0] m;
      m = 7'd0;
      if (ext) begin
         if (code == 8'h5A) m = {1'b1, 3'd0, 3'd1};
      end else begin
         case (code)
            8'h5A:   m = {1'b1, 3'd0, 3'd1};
            8'h29:   m = {1'b1, 3'd0, 3'd2};
            8'h59:   m = {1'b1, 3'd0, 3'd6};
            8'h12:   m = {1'b1, 3'd0, 3'd7};
            8'h32:   m = {1'b1, 3'd1, 3'd0};
            8'h21:   m = {1'b1, 3'd2, 3'd0};
            8'h23:   m = {1'b1, 3'd3, 3'd0};
            8'h24:   m = {1'b1, 3'd4, 3'd0};
            8'h2B:   m = {1'b1, 3'd5, 3'd0};
            8'h1C:   m = {1'b1, 3'd6, 3'd0};
            8'h16:   m = {1'b1, 3'd7, 3'd0};
            8'h1E:   m = {1'b1, 3'd7, 3'd1};
            8'h26:   m = {1'b1, 3'd7, 3'd2};
            default: m = 7'd0;
         endcase
      end
      return m;
   endfunction

   state_e                     state_q, state_d;
   logic                       tog_q, tog_d;
   logic [9:0]                 evt_q, evt_d;
   logic [6:0]                 map_q, map_d;
   logic [63:0]                key_q, key_d;
   logic [HW-1:0]              hold_q, hold_d;
   logic [RQ_DEPTH-1:0][5:0]   rq_mem_q, rq_mem_d;
   logic [AW:0]                rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;
   logic [7:0]                 row_out_q, row_out_d;
   logic                       key_event_q, key_event_d;
   logic                       rq_ovf_q, rq_ovf_d;
   logic                       rq_empty, rq_full;

   always_comb begin
      state_d     = state_q;
      tog_d       = tog_q;
      evt_d       = evt_q;
      key_d       = key_q;
      rq_mem_d    = rq_mem_q;
      rq_wr_d     = rq_wr_q;
      rq_rd_d     = rq_rd_q;
      rq_ovf_d    = rq_ovf_q;
      key_event_d = 1'b0;
      map_d       = kbd_map(evt_q[8], evt_q[7:0]);
      hold_d      = (hold_q != '0) ? hold_q - 1'b1 : '0;
      rq_empty    = (rq_wr_q == rq_rd_q);
      rq_full     = (rq_wr_q[AW] != rq_rd_q[AW]) && (rq_wr_q[AW-1:0] == rq_rd_q[AW-1:0]);

      // Pop is applied first so a same-cycle APPLY on the same bit overrides it
      if ((hold_q == '0) && !rq_empty) begin
         key_d[rq_mem_q[rq_rd_q[AW-1:0]]] = 1'b0;
         rq_rd_d = rq_rd_q + 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (ps2_key[10] != tog_q) begin
               evt_d   = ps2_key[9:0];
               tog_d   = ps2_key[10];
               state_d = StLookup;
            end
         end
         StLookup: state_d = StApply;
         StApply: begin
            state_d = StIdle;
            if (map_q[6]) begin
               if (evt_q[9]) begin
                  key_d[map_q[5:0]] = 1'b1;
                  hold_d            = HW'(MIN_HOLD);
                  key_event_d       = 1'b1;
               end else if (hold_q == '0) begin
                  key_d[map_q[5:0]] = 1'b0;
                  key_event_d       = 1'b1;
               end else if (rq_full) begin
                  key_d[map_q[5:0]] = 1'b0;
                  rq_ovf_d          = 1'b1;
                  key_event_d       = 1'b1;
               end else begin
                  rq_mem_d[rq_wr_q[AW-1:0]] = map_q[5:0];
                  rq_wr_d                   = rq_wr_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (!kbd_en) begin
         key_d       = '0;
         rq_wr_d     = '0;
         rq_rd_d     = '0;
         hold_d      = '0;
         state_d     = StIdle;
         tog_d       = ps2_key[10];
         key_event_d = 1'b0;
      end

      for (int r = 0; r < 8; r++) begin
         row_out_d[r] = ~|(key_q[r*8 +: 8] & ~col_sel);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         tog_q       <= ps2_key[10];
         evt_q       <= '0;
         map_q       <= '0;
         key_q       <= '0;
         hold_q      <= '0;
         rq_mem_q    <= '0;
         rq_wr_q     <= '0;
         rq_rd_q     <= '0;
         row_out_q   <= 8'hFF;
         key_event_q <= 1'b0;
         rq_ovf_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         tog_q       <= tog_d;
         evt_q       <= evt_d;
         map_q       <= map_d;
         key_q       <= key_d;
         hold_q      <= hold_d;
         rq_mem_q    <= rq_mem_d;
         rq_wr_q     <= rq_wr_d;
         rq_rd_q     <= rq_rd_d;
         row_out_q   <= row_out_d;
         key_event_q <= key_event_d;
         rq_ovf_q    <= rq_ovf_d;
      end
   end

   assign row_out     = row_out_q;
   assign key_event   = key_event_q;
   assign rq_overflow = rq_ovf_q;

endmodule
